// File: rtl/conv_psum_requant.sv
// Back end of the 3x3 conv adder tree: tracks valid beats through the tree latency,
// accumulates per-channel sums, adds bias, rounds/shifts/ReLUs/saturates and buffers results.
module conv_psum_requant #(
  parameter int TREE_LAT = 4,
  parameter int DEPTH    = 8,
  parameter int CH_W     = 10,
  parameter int OUT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   cfg_num_ch,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic [31:0]       bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       tree_sum,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [32:0] SAT_MAX = 33'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [32:0] SAT_MIN = -SAT_MAX - 33'sd1;

  // Valid/ready: the feeder's beat is taken on a clock edge where in_valid & in_ready are
  // both high; a result leaves on an edge where out_valid & out_ready are both high.

  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [TREE_LAT-1:0] dl_valid_q, dl_valid_d;
  logic [TREE_LAT-1:0] dl_first_q, dl_first_d;
  logic [TREE_LAT-1:0] dl_last_q, dl_last_d;
  logic [31:0]         dl_bias_q [TREE_LAT];
  logic [31:0]         dl_bias_d [TREE_LAT];
  logic [31:0]         acc_q, acc_d;
  logic                a_valid_q, a_valid_d;
  logic [31:0]         a_pre_q, a_pre_d;
  logic                b_valid_q, b_valid_d;
  logic [OUT_W-1:0]    b_data_q, b_data_d;
  logic [OUT_W-1:0]    mem_q [DEPTH];
  logic [OUT_W-1:0]    mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       inflight_q, inflight_d;

  logic [CH_W-1:0]     num_eff;
  logic                accept, beat_first, beat_last;
  logic                tail_valid, tail_first, tail_last;
  logic [31:0]         tail_bias, acc_next;
  logic signed [32:0]  pre_ext, rnd, rounded, shifted, relu_v, sat_v;
  logic                push, pop;
  logic [CW:0]         occupancy;

  always_comb begin
    num_eff    = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
    occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
    in_ready   = occupancy < (CW + 1)'(DEPTH);
    accept     = in_valid & in_ready;
    beat_first = (ch_cnt_q == '0);
    beat_last  = (ch_cnt_q == num_eff - CH_W'(1));

    ch_cnt_d = ch_cnt_q;
    if (accept) ch_cnt_d = beat_last ? '0 : ch_cnt_q + CH_W'(1);

    // Beat tags travel alongside the tree so they line up with its sum at the tail.
    dl_valid_d = dl_valid_q;
    dl_first_d = dl_first_q;
    dl_last_d  = dl_last_q;
    for (int i = 0; i < TREE_LAT; i++) dl_bias_d[i] = dl_bias_q[i];
    for (int i = TREE_LAT - 1; i > 0; i--) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_first_d[i] = dl_first_q[i-1];
      dl_last_d[i]  = dl_last_q[i-1];
      dl_bias_d[i]  = dl_bias_q[i-1];
    end
    dl_valid_d[0] = accept;
    dl_first_d[0] = accept & beat_first;
    dl_last_d[0]  = accept & beat_last;
    dl_bias_d[0]  = (accept & beat_last) ? bias : '0;

    tail_valid = dl_valid_q[TREE_LAT-1];
    tail_first = dl_first_q[TREE_LAT-1];
    tail_last  = dl_last_q[TREE_LAT-1];
    tail_bias  = dl_bias_q[TREE_LAT-1];

    acc_next  = tail_first ? tree_sum : acc_q + tree_sum;
    acc_d     = tail_valid ? acc_next : acc_q;
    a_valid_d = tail_valid & tail_last;
    a_pre_d   = a_valid_d ? acc_next + tail_bias : a_pre_q;

    // 33-bit intermediate so the rounding increment cannot wrap.
    pre_ext = {a_pre_q[31], a_pre_q};
    rnd     = (cfg_shift != 5'd0) ? (33'sd1 <<< (cfg_shift - 5'd1)) : 33'sd0;
    rounded = pre_ext + rnd;
    shifted = rounded >>> cfg_shift;
    relu_v  = (cfg_relu && shifted < 33'sd0) ? 33'sd0 : shifted;
    if (relu_v > SAT_MAX)      sat_v = SAT_MAX;
    else if (relu_v < SAT_MIN) sat_v = SAT_MIN;
    else                       sat_v = relu_v;
    b_valid_d = a_valid_q;
    b_data_d  = a_valid_q ? sat_v[OUT_W-1:0] : b_data_q;

    push = b_valid_q;
    pop  = (count_q != '0) & out_ready;

    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q] = b_data_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // Reserved slots for accepted groups; the credit comes back only on the push.
    inflight_d = inflight_q;
    if ((accept & beat_last) && !push)      inflight_d = inflight_q + CW'(1);
    else if (!(accept & beat_last) && push) inflight_d = inflight_q - CW'(1);

    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    busy      = (ch_cnt_q != '0) | (|dl_valid_q) | a_valid_q | b_valid_q | out_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q   <= '0;
      dl_valid_q <= '0;
      dl_first_q <= '0;
      dl_last_q  <= '0;
      for (int i = 0; i < TREE_LAT; i++) dl_bias_q[i] <= '0;
      acc_q      <= '0;
      a_valid_q  <= 1'b0;
      a_pre_q    <= '0;
      b_valid_q  <= 1'b0;
      b_data_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      ch_cnt_q   <= ch_cnt_d;
      dl_valid_q <= dl_valid_d;
      dl_first_q <= dl_first_d;
      dl_last_q  <= dl_last_d;
      for (int i = 0; i < TREE_LAT; i++) dl_bias_q[i] <= dl_bias_d[i];
      acc_q      <= acc_d;
      a_valid_q  <= a_valid_d;
      a_pre_q    <= a_pre_d;
      b_valid_q  <= b_valid_d;
      b_data_q   <= b_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: tb/tb_conv_psum_requant.sv
// Bench for conv_psum_requant: a 4-stage tree model feeds sums, an arithmetic reference
// model fills exp_q, and a negedge monitor checks every popped result against it.
module tb_conv_psum_requant;
  localparam int TREE_LAT = 4;
  localparam int DEPTH    = 8;
  localparam int CH_W     = 10;
  localparam int OUT_W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH_W-1:0]   cfg_num_ch = 10'd1;
  logic [4:0]        cfg_shift = 5'd0;
  logic              cfg_relu = 1'b0;
  logic [31:0]       bias = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       tree_sum;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;

  conv_psum_requant #(.TREE_LAT(TREE_LAT), .DEPTH(DEPTH), .CH_W(CH_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .cfg_num_ch(cfg_num_ch), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .tree_sum(tree_sum),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // ---------------- clock / reset / tree model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] feed_sum = '0;
  logic [31:0] tree_pipe [TREE_LAT];
  always @(posedge clk) begin
    tree_pipe[0] <= feed_sum;
    for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_sum = tree_pipe[TREE_LAT-1];

  // ---------------- reference model + scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] obs_q[$];
  int m_ch  = 0;
  int m_acc = 0;
  int last_accept_cyc = 0;
  bit seen_valid = 0;
  int first_valid_cyc = 0;

  function automatic logic [OUT_W-1:0] ref_requant(input int pre, input int sh, input bit relu);
    longint v;
    v = longint'(pre);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[OUT_W-1:0];
  endfunction

  function automatic void model_beat(input int sum, input int b);
    int eff;
    eff = (cfg_num_ch == 0) ? 1 : int'(cfg_num_ch);
    if (m_ch == 0) m_acc = sum;
    else m_acc = m_acc + sum;
    m_ch++;
    if (m_ch == eff) begin
      m_ch = 0;
      exp_q.push_back(ref_requant(m_acc + b, int'(cfg_shift), cfg_relu));
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (out_ready) begin
        n_tests++;
        obs_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got %0d, expected no output", $signed(out_data));
        end else begin
          logic [OUT_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL scoreboard_data: got %0d, expected %0d", $signed(out_data), $signed(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input int sum, input int b);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL drive_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
    end else begin
      in_valid = 1'b1;
      feed_sum = sum;
      bias = b;
      model_beat(sum, b);
      last_accept_cyc = cyc + 1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      feed_sum = $urandom;
      bias = $urandom;
    end
  endtask

  task automatic wait_drain(output bit ok);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    ok = (exp_q.size() == 0) && !busy;
  endtask

  task automatic set_cfg(input int nch, input int sh, input bit relu);
    cfg_num_ch = CH_W'(nch);
    cfg_shift  = 5'(sh);
    cfg_relu   = relu;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    m_ch = 0;
    m_acc = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    n_tests++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
  endtask

  task automatic test_single_channel();
    logic [OUT_W-1:0] want [4];
    int first_acc;
    bit ok;
    want[0] = 8'd5; want[1] = 8'hFD; want[2] = 8'd127; want[3] = 8'h80;
    set_cfg(1, 0, 0);
    out_ready = 1'b1;
    obs_q.delete();
    seen_valid = 0;
    first_acc = cyc + 1;
    drive_beat(5, 0);
    drive_beat(-3, 0);
    drive_beat(200, 0);
    drive_beat(-200, 0);
    wait_drain(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_drain: busy=%0b pending=%0d, expected idle", busy, exp_q.size()); end
    n_tests++;
    if (first_valid_cyc - first_acc != 6) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles, expected 6", first_valid_cyc - first_acc);
    end
    n_tests++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL single_count: got %0d outputs, expected 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== want[i]) begin
        n_fail++; $display("FAIL single_value[%0d]: got %0d, expected %0d", i, $signed(obs_q[i]), $signed(want[i]));
      end
    end
  endtask

  task automatic test_accumulate_bias();
    bit ok;
    set_cfg(3, 4, 0);
    obs_q.delete();
    drive_beat(100, int'($urandom));
    drive_beat(200, int'($urandom));
    drive_beat(300, 40);
    wait_drain(ok);
    n_tests++;
    if (!ok || obs_q.size() != 1) begin
      n_fail++; $display("FAIL accum_count: got %0d outputs, expected 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== 8'd40) begin n_fail++; $display("FAIL accum_value: got %0d, expected 40", $signed(obs_q[0])); end
    end
  endtask

  task automatic test_round_relu();
    bit ok;
    set_cfg(1, 1, 0);
    obs_q.delete();
    drive_beat(23, 0);
    drive_beat(-23, 0);
    wait_drain(ok);
    set_cfg(1, 0, 1);
    drive_beat(-50, 0);
    wait_drain(ok);
    n_tests++;
    if (!ok || obs_q.size() != 3) begin
      n_fail++; $display("FAIL round_count: got %0d outputs, expected 3", obs_q.size());
    end else begin
      n_tests++; if (obs_q[0] !== 8'd12) begin n_fail++; $display("FAIL round_pos: got %0d, expected 12", $signed(obs_q[0])); end
      n_tests++; if (obs_q[1] !== 8'hF5) begin n_fail++; $display("FAIL round_neg: got %0d, expected -11", $signed(obs_q[1])); end
      n_tests++; if (obs_q[2] !== 8'd0) begin n_fail++; $display("FAIL relu_clamp: got %0d, expected 0", $signed(obs_q[2])); end
    end
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    bit ok;
    set_cfg(1, 0, 0);
    obs_q.delete();
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      feed_sum = $urandom_range(0, 400) - 200;
      bias = $urandom_range(0, 20) - 10;
      if (in_ready) begin
        model_beat(int'(feed_sum), int'(bias));
        acc_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_tests++; if (acc_cnt != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d beats, expected 8", acc_cnt); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b, expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held: out_valid=%0b, expected 1", out_valid); end
    out_ready = 1'b1;
    wait_drain(ok);
    n_tests++;
    if (!ok || obs_q.size() != 8) begin
      n_fail++; $display("FAIL bp_drain: got %0d outputs, expected 8", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_group();
    bit ok;
    set_cfg(4, 0, 0);
    drive_beat(1000, 0);
    drive_beat(2000, 0);
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %0b, expected 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b, expected 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b, expected 0", busy); end
    for (int i = 0; i < 4; i++) drive_beat(10, 0);
    wait_drain(ok);
    n_tests++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== 8'd40) begin
      n_fail++; $display("FAIL midrst_group: got %0d outputs first=%0d, expected 1 output of 40",
                         obs_q.size(), (obs_q.size() > 0) ? int'($signed(obs_q[0])) : 0);
    end
  endtask

  task automatic test_back_to_back();
    int a8;
    bit ok;
    set_cfg(1, 0, 0);
    obs_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_beat(int'($urandom_range(0, 300)) - 150, int'($urandom_range(0, 10)));
    a8 = last_accept_cyc;
    while (cyc < a8 + 5) begin @(posedge clk); #1; end
    // FIFO holds 7, one result still in flight.
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_in_ready: got %0b, expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_full_valid: got %0b, expected 1", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pushpop_in_ready: got %0b, expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pushpop_valid: got %0b, expected 1", out_valid); end
    wait_drain(ok);
    n_tests++;
    if (!ok || obs_q.size() != 8) begin
      n_fail++; $display("FAIL b2b_drain: got %0d outputs, expected 8", obs_q.size());
    end
  endtask

  bit rnd_done;
  task automatic test_random();
    bit ok;
    for (int r = 0; r < 6; r++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 14), 1'($urandom_range(0, 1)));
      obs_q.delete();
      rnd_done = 0;
      fork
        begin
          for (int g = 0; g < 6; g++) begin
            int nch;
            nch = (cfg_num_ch == 0) ? 1 : int'(cfg_num_ch);
            for (int c = 0; c < nch; c++)
              drive_beat(int'($urandom_range(0, 1 << 21)) - (1 << 20), int'($urandom_range(0, 1 << 16)) - (1 << 15));
          end
          rnd_done = 1;
        end
        begin
          while (!rnd_done) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
          end
          out_ready = 1'b1;
        end
      join
      wait_drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL random_drain[%0d]: pending=%0d busy=%0b, expected idle", r, exp_q.size(), busy); end
    end
  endtask

  initial begin
    feed_sum = $urandom;
    test_reset();
    test_single_channel();
    test_accumulate_bias();
    test_round_relu();
    test_backpressure();
    test_reset_mid_group();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
